// File: rtl/spiking_pkg.sv
// Shared definitions for the spiking datapath (encoder and spiking_pe).
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package spiking_pkg;

  // Default activation width shared by the encoder and the PE array.
  localparam int DEFAULT_DATA_WIDTH = 16;

  // Encoder control states.
  typedef enum logic {
    IDLE   = 1'b0,
    ENCODE = 1'b1
  } enc_state_t;

endpackage

// File: rtl/spike_accumulator.sv
// Rate-coding accumulator: adds the held value each step and fires on threshold crossing.
// Latency: spike is combinational from acc/value; acc updates on the step edge.
// Backpressure: none; acc only moves when acc_step is asserted.
//
// Ports:
//   clk, rstn   - clock, asynchronous active-low reset
//   acc_clear   - zero the accumulator (has priority over acc_step)
//   acc_step    - commit this cycle's accumulate/subtract
//   value       - clamped activation, zero-extended to AW bits
//   spike       - 1 when acc + value reaches THRESHOLD
module spike_accumulator #(
  parameter int AW        = 17,
  parameter int THRESHOLD = 256
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          acc_clear,
  input  logic          acc_step,
  input  logic [AW-1:0] value,
  output logic          spike
);

  localparam logic [AW-1:0] THR = AW'(THRESHOLD);

  logic [AW-1:0] acc;
  logic [AW-1:0] sum;

  // value <= THRESHOLD and acc < THRESHOLD, so sum < 2*THRESHOLD fits in AW bits.
  always_comb begin
    sum   = acc + value;
    spike = (sum >= THR);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      acc <= '0;
    end else if (acc_clear) begin
      acc <= '0;
    end else if (acc_step) begin
      acc <= spike ? (sum - THR) : sum;
    end
  end

endmodule

// File: rtl/spike_row_encoder.sv
// Converts one signed activation into NUM_STEPS rate-coded spike bits for a PE row.
// Latency: each spike appears one cycle after the step_en cycle that produced it.
// Backpressure: in_ready only in IDLE; step_en=0 stalls the encoding in place.
//
// Ports:
//   clk, rstn            - clock, asynchronous active-low reset
//   in_valid/in_ready    - activation handshake, in_data is signed
//   step_en              - downstream row advances one timestep
//   clear                - synchronous abort, wins over step_en and in_valid
//   out_row/out_valid    - registered spike bit and its qualifier
//   out_last             - marks the final timestep of the value
module spike_row_encoder
  import spiking_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int NUM_STEPS  = 8,
  parameter int THRESHOLD  = 256
) (
  input  logic                         clk,
  input  logic                         rstn,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic signed [DATA_WIDTH-1:0] in_data,
  input  logic                         step_en,
  input  logic                         clear,
  output logic                         out_row,
  output logic                         out_valid,
  output logic                         out_last
);

  localparam int                    AW       = DATA_WIDTH + 1;
  localparam int                    CW       = $clog2(NUM_STEPS) + 1;
  localparam logic [CW-1:0]         LAST_CNT = CW'(NUM_STEPS - 1);
  localparam logic [DATA_WIDTH-1:0] THR_DW   = DATA_WIDTH'(THRESHOLD);

  enc_state_t            state;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] value;
  logic [DATA_WIDTH-1:0] clamped;
  logic                  accept;
  logic                  do_step;
  logic                  spike;

  assign in_ready = (state == IDLE);
  assign accept   = in_ready && in_valid && !clear;
  assign do_step  = (state == ENCODE) && step_en && !clear;

  // Negative activations never fire; anything above threshold fires every step.
  always_comb begin
    if (in_data[DATA_WIDTH-1]) begin
      clamped = '0;
    end else if ($unsigned(in_data) > THR_DW) begin
      clamped = THR_DW;
    end else begin
      clamped = $unsigned(in_data);
    end
  end

  // Accumulator is zeroed on every new value and on abort.
  spike_accumulator #(
    .AW        (AW),
    .THRESHOLD (THRESHOLD)
  ) u_acc (
    .clk       (clk),
    .rstn      (rstn),
    .acc_clear (clear || accept),
    .acc_step  (do_step),
    .value     ({1'b0, value}),
    .spike     (spike)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      cnt       <= '0;
      value     <= '0;
      out_row   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      // Outputs default to idle; only an issued step raises them.
      out_row   <= 1'b0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      if (clear) begin
        state <= IDLE;
        cnt   <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (in_valid) begin
              value <= clamped;
              cnt   <= '0;
              state <= ENCODE;
            end
          end
          ENCODE: begin
            if (step_en) begin
              out_row   <= spike;
              out_valid <= 1'b1;
              out_last  <= (cnt == LAST_CNT);
              if (cnt == LAST_CNT) begin
                cnt   <= '0;
                state <= IDLE;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_spike_row_encoder.sv
module tb_spike_row_encoder;

  logic               clk;
  logic               rstn;
  logic               in_valid;
  logic               in_ready;
  logic signed [15:0] in_data;
  logic               step_en;
  logic               clear;
  logic               out_row;
  logic               out_valid;
  logic               out_last;

  int n_cmp = 0;
  int n_bad = 0;

  spike_row_encoder #(
    .DATA_WIDTH (16),
    .NUM_STEPS  (8),
    .THRESHOLD  (256)
  ) dut (
    .clk       (clk),
    .rstn      (rstn),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .step_en   (step_en),
    .clear     (clear),
    .out_row   (out_row),
    .out_valid (out_valid),
    .out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic signed [15:0] d;
    logic [7:0]         rows;  // bit i = spike on timestep i+1
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Offer one value; returns one cycle after the accepting edge.
  task automatic send(input logic signed [15:0] d);
    @(posedge clk); #1;
    check("in_ready_before_send", {31'd0, in_ready}, 32'd1);
    in_valid = 1'b1;
    in_data  = d;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_data  = 16'sd0;
  endtask

  // Gather up to 8 timesteps; stall=1 drives step_en as 1,0,0,1,0,0,...
  task automatic collect(input bit stall, output logic [7:0] rows, output logic [7:0] lasts,
                         output int nsteps, output int bad_valid);
    logic prev_en;
    rows = '0; lasts = '0; nsteps = 0; bad_valid = 0;
    prev_en = 1'b0;
    for (int cyc = 0; cyc < 100; cyc++) begin
      if (out_valid !== prev_en) bad_valid++;
      if (out_valid === 1'b1) begin
        rows[nsteps]  = out_row;
        lasts[nsteps] = out_last;
        nsteps++;
        if (nsteps == 8) break;
      end
      prev_en = stall ? (cyc % 3 == 0) : 1'b1;
      step_en = prev_en;
      @(posedge clk); #1;
    end
  endtask

  vec_t vecs[7];

  initial begin
    logic [7:0] rows;
    logic [7:0] lasts;
    int         nsteps;
    int         bad_valid;
    int         seen;

    vecs[0] = '{d: 16'sd128,  rows: 8'hAA};
    vecs[1] = '{d: 16'sd64,   rows: 8'h88};
    vecs[2] = '{d: 16'sd256,  rows: 8'hFF};
    vecs[3] = '{d: -16'sd5,   rows: 8'h00};
    vecs[4] = '{d: 16'sd1000, rows: 8'hFF};
    vecs[5] = '{d: 16'sd192,  rows: 8'hEE};
    vecs[6] = '{d: 16'sd32,   rows: 8'h80};

    rstn = 1'b0; in_valid = 1'b0; in_data = '0; step_en = 1'b1; clear = 1'b0;
    #12;
    check("rst_in_ready",  {31'd0, in_ready},  32'd1);
    check("rst_out_valid", {31'd0, out_valid}, 32'd0);
    check("rst_out_row",   {31'd0, out_row},   32'd0);
    check("rst_out_last",  {31'd0, out_last},  32'd0);
    @(negedge clk); rstn = 1'b1;

    // step_en held high while IDLE must not produce anything
    repeat (3) @(posedge clk);
    #1;
    check("idle_no_step", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 7; i++) begin
      send(vecs[i].d);
      collect(1'b0, rows, lasts, nsteps, bad_valid);
      check($sformatf("vec%0d_rows", i),   {24'd0, rows},  {24'd0, vecs[i].rows});
      check($sformatf("vec%0d_lasts", i),  {24'd0, lasts}, 32'h80);
      check($sformatf("vec%0d_nsteps", i), nsteps,         32'd8);
      check($sformatf("vec%0d_ready", i),  {31'd0, in_ready}, 32'd1);
    end

    // Stalled stepping: same spikes, out_valid only after step_en cycles
    step_en = 1'b0;
    send(16'sd128);
    collect(1'b1, rows, lasts, nsteps, bad_valid);
    check("stall_rows",      {24'd0, rows},  32'hAA);
    check("stall_lasts",     {24'd0, lasts}, 32'h80);
    check("stall_nsteps",    nsteps,         32'd8);
    check("stall_valid_bad", bad_valid,      32'd0);
    step_en = 1'b1;

    // Clear after step 3, then a fresh 256 encodes 8 spikes
    send(16'sd128);
    rows = '0;
    for (int s = 0; s < 3; s++) begin
      @(posedge clk); #1;
      check($sformatf("clr_pre_valid%0d", s), {31'd0, out_valid}, 32'd1);
      rows[s] = out_row;
    end
    check("clr_pre_rows", {24'd0, rows}, 32'h02);
    clear = 1'b1;
    @(posedge clk); #1;
    clear = 1'b0;
    check("clr_valid", {31'd0, out_valid}, 32'd0);
    check("clr_ready", {31'd0, in_ready},  32'd1);
    send(16'sd256);
    collect(1'b0, rows, lasts, nsteps, bad_valid);
    check("post_clr_rows",   {24'd0, rows},  32'hFF);
    check("post_clr_lasts",  {24'd0, lasts}, 32'h80);
    check("post_clr_nsteps", nsteps,         32'd8);

    // clear wins over in_valid in IDLE
    @(posedge clk); #1;
    clear = 1'b1; in_valid = 1'b1; in_data = 16'sd100;
    @(posedge clk); #1;
    clear = 1'b0; in_valid = 1'b0;
    check("clr_blocks_accept", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    check("clr_blocks_step", {31'd0, out_valid}, 32'd0);

    // Reset mid-encoding
    send(16'sd128);
    @(posedge clk); #1;
    @(posedge clk); #1;
    check("rst_mid_row_before", {31'd0, out_row}, 32'd1);
    rstn = 1'b0;
    #1;
    check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
    check("rst_mid_row",   {31'd0, out_row},   32'd0);
    check("rst_mid_ready", {31'd0, in_ready},  32'd1);
    @(negedge clk); @(negedge clk);
    rstn = 1'b1;
    seen = 0;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      if (out_valid !== 1'b0) seen++;
    end
    check("rst_mid_no_spikes", seen, 32'd0);
    check("rst_mid_ready_rel", {31'd0, in_ready}, 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
